// File: rtl/dm_store_buffer.sv
// Word-store write buffer that sits in front of the single-port data memory.
// Stores queue in a FIFO and drain when no load needs the port; loads that hit a queued store are forwarded from it.
module dm_store_buffer #(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        st_valid,
    input  logic [13:2] st_addr,
    input  logic [31:0] st_data,
    input  logic [31:0] st_pc,
    input  logic        ld_valid,
    input  logic [13:2] ld_addr,
    input  logic [31:0] dm_rdata,
    output logic        dm_we,
    output logic [13:2] dm_addr,
    output logic [31:0] dm_data,
    output logic [31:0] dm_pc,
    output logic [31:0] ld_data,
    output logic        stall,
    output logic        empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    logic [13:2] addr_mem [DEPTH];
    logic [31:0] data_mem [DEPTH];
    logic [31:0] pc_mem   [DEPTH];

    logic [AW-1:0] head_reg;
    logic [AW-1:0] tail_reg;
    logic [AW:0]   count_reg;
    logic [AW:0]   count_next;

    logic push;
    logic pop;

    assign stall = st_valid && (count_reg == FULL_COUNT);
    assign push  = st_valid && !stall;
    assign pop   = (count_reg != '0) && !ld_valid;
    assign empty = (count_reg == '0);

    // Port arbitration: a load owns the port, otherwise the head entry drains.
    assign dm_we   = pop;
    assign dm_addr = ld_valid ? ld_addr : (pop ? addr_mem[head_reg] : '0);
    assign dm_data = pop ? data_mem[head_reg] : '0;
    assign dm_pc   = pop ? pc_mem[head_reg] : '0;

    // Slot gi is the gi-th oldest occupied entry counting from head.
    logic [AW-1:0]    slot_idx [DEPTH];
    logic [DEPTH-1:0] hit;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_match
            assign slot_idx[gi] = head_reg + AW'(gi);
            assign hit[gi]      = ((AW+1)'(gi) < count_reg) && (addr_mem[slot_idx[gi]] == ld_addr);
        end
    endgenerate

    logic        fwd_hit;
    logic [31:0] fwd_data;

    // Scanning oldest to youngest lets the youngest match overwrite older ones.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (hit[i]) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem[slot_idx[i]];
            end
        end
    end

    assign ld_data = (ld_valid && fwd_hit) ? fwd_data : dm_rdata;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_reg  <= '0;
            tail_reg  <= '0;
            count_reg <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem[i] <= '0;
                data_mem[i] <= '0;
                pc_mem[i]   <= '0;
            end
        end else begin
            if (push) begin
                addr_mem[tail_reg] <= st_addr;
                data_mem[tail_reg] <= st_data;
                pc_mem[tail_reg]   <= st_pc;
                tail_reg           <= tail_reg + AW'(1);
            end
            if (pop) begin
                head_reg <= head_reg + AW'(1);
            end
            count_reg <= count_next;
        end
    end

endmodule
